keystream_xor: RTL and testbench
================================

# keystream_xor

Byte-serial XOR stage of the stream cipher, directly downstream of the hash generator. It accepts one plaintext (or ciphertext) byte at a time on a valid/ready handshake, requests one keystream byte from the hash generator, XORs the two bytes, and presents the result on a valid/ready output. It also owns session restart: it pulses the generator's hash reset and clears its own counters, and it flags a generator that stops answering.

## Interface
Parameters:
- KEY_TIMEOUT, default 64: maximum number of cycles spent in WAIT_KEY before the request is abandoned. Must be at least 2.
- COUNT_WIDTH, default 16: width of the processed-byte counter.

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- session_start  in  1  single-cycle pulse that restarts the keystream session.
- data_in  in  8  input byte.
- data_in_valid  in  1  input byte valid.
- data_in_ready  out  1  block can accept an input byte.
- data_out  out  8  data_in XOR keystream byte.
- data_out_valid  out  1  data_out valid.
- data_out_ready  in  1  consumer accepts data_out.
- request_hash_byte_pulse  out  1  one-cycle keystream byte request to the hash generator.
- hash_byte_in  in  8  keystream byte from the generator; sampled only while hash_byte_pulse_in is high.
- hash_byte_pulse_in  in  1  keystream byte valid strobe from the generator.
- reset_hash  out  1  one-cycle reset pulse to the hash generator.
- byte_count  out  COUNT_WIDTH  number of output bytes delivered in this session.
- key_error  out  1  sticky flag: a keystream request timed out.

## Operation
State machine with four states: IDLE, REQUEST, WAIT_KEY, OUTPUT.

- **IDLE**
  - data_in_ready = 1, except in a cycle where session_start = 1.
  - On data_in_valid & data_in_ready: latch data_in into the hold register, then go to REQUEST.
- **REQUEST**
  - Drive request_hash_byte_pulse = 1 for exactly this one cycle.
  - Clear the timeout counter, then go to WAIT_KEY.
- **WAIT_KEY**
  - The timeout counter increments every cycle.
  - If hash_byte_pulse_in = 1: set data_out = hold ^ hash_byte_in and data_out_valid = 1, then go to OUTPUT.
  - Else, if the counter reaches KEY_TIMEOUT-1: set key_error = 1, drop the held byte, and go to IDLE. No output is produced.
  - If the strobe arrives in the same cycle the counter reaches KEY_TIMEOUT-1, the strobe wins.
- **OUTPUT**
  - data_out and data_out_valid are held stable until data_out_ready = 1.
  - On the handshake: clear data_out_valid, increment byte_count (wraps modulo 2^COUNT_WIDTH), then go to IDLE.
- **hash_byte_pulse_in outside WAIT_KEY**: ignored. It does not affect the state, data_out or byte_count.
- **session_start** (any state):
  - Next state is IDLE and data_out_valid goes to 0; any in-flight byte is discarded.
  - byte_count and key_error are cleared.
  - reset_hash = 1 for exactly the following cycle.
  - session_start has priority over every other event in the same cycle, including handshakes.
- **XOR** is symmetric, so the same block encrypts and decrypts. There is no mode input.

## Timing
- **Reset** (rst = 1 at a clock edge): state IDLE; data_out = 0; data_out_valid = 0; request_hash_byte_pulse = 0; reset_hash = 1 for the cycle after the reset edge; byte_count = 0; key_error = 0; timeout counter = 0.
  - data_in_ready = 1 from the first cycle after rst deasserts.
- **All outputs are registered**, except data_in_ready, which is decoded from the state.
- **Latency**: input handshake at cycle N → request pulse visible in N+1 → WAIT_KEY from N+2.
  - Strobe sampled at cycle M → data_out_valid high in M+1.
  - Best case: 3 cycles from input acceptance to data_out_valid.
- **Throughput**: at most one byte per 4 cycles (IDLE, REQUEST, WAIT_KEY, OUTPUT), each with minimum dwell.
- **request_hash_byte_pulse** is never high for two consecutive cycles and is never reissued while in WAIT_KEY.
- **reset_hash and request_hash_byte_pulse** are never high in the same cycle.

## Test plan
- **Reset**: assert rst for 2 cycles → all outputs at their reset values, and reset_hash high in the cycle after each reset edge. After release, data_in_ready = 1.
- **Single byte**: send data_in = 8'h5A; the generator model answers with hash_byte_in = 8'hC3 two cycles after the request, and data_out_ready is held high → data_out = 8'h99, data_out_valid high for 1 cycle, byte_count = 1. Exactly one request pulse is observed.
- **Backpressure**: same stimulus with data_out_ready low for 5 cycles → data_out stays 8'h99 and valid stays high throughout, data_in_ready stays 0, and no second request is issued.
- **Timeout**: with KEY_TIMEOUT = 8, the generator never answers → key_error rises 8 cycles after the first WAIT_KEY cycle, no output is produced, byte_count is unchanged, and the block is back in IDLE. A later successful byte leaves key_error at 1.
- **Session restart mid-byte**: assert session_start while in WAIT_KEY, then fire a stray hash strobe 1 cycle later → no output, reset_hash pulses once, byte_count = 0, key_error = 0. The stray strobe is ignored.
- **Stream and wrap**: with COUNT_WIDTH = 4, run 17 back-to-back bytes against a generator that returns keystream bytes 0x00..0x10 → every output equals input XOR its keystream byte, in order, and byte_count ends at 1.

Source files
------------

// File: rtl/keystream_xor_if.sv
// Byte stream and keystream-request bundle for keystream_xor.
//   data_in / data_in_valid / data_in_ready     : input byte stream
//   data_out / data_out_valid / data_out_ready  : XORed output stream
//   request_hash_byte_pulse                     : keystream byte request
//   hash_byte_in / hash_byte_pulse_in           : keystream byte answer
// slave is the cipher stage view, master is the surrounding system view.
interface keystream_xor_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       request_hash_byte_pulse;
  logic [7:0] hash_byte_in;
  logic       hash_byte_pulse_in;

  modport slave (
    input  data_in, data_in_valid, data_out_ready, hash_byte_in, hash_byte_pulse_in,
    output data_in_ready, data_out, data_out_valid, request_hash_byte_pulse
  );

  modport master (
    output data_in, data_in_valid, data_out_ready, hash_byte_in, hash_byte_pulse_in,
    input  data_in_ready, data_out, data_out_valid, request_hash_byte_pulse
  );
endinterface

// File: rtl/keystream_xor.sv
// Byte-serial XOR stage of the stream cipher.
// Takes one byte, requests one keystream byte from the hash generator,
// presents data ^ key, and owns session restart and generator timeout.
//   clk, rst      : clock, synchronous active-high reset
//   session_start : one-cycle pulse, restarts the keystream session
//   bus (slave)   : input/output byte streams and keystream request/answer
//   reset_hash    : one-cycle reset pulse to the hash generator
//   byte_count    : bytes delivered this session (wraps)
//   key_error     : sticky, a keystream request timed out
module keystream_xor #(
  parameter int KEY_TIMEOUT = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   session_start,
  keystream_xor_if.slave         bus,
  output logic                   reset_hash,
  output logic [COUNT_WIDTH-1:0] byte_count,
  output logic                   key_error
);

  localparam int TW = (KEY_TIMEOUT > 2) ? $clog2(KEY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(KEY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_KEY, OUTPUT} state_t;

  state_t                 state_q;
  logic [7:0]             hold_q;
  logic [7:0]             dout_q;
  logic                   dval_q;
  logic                   req_q;
  logic                   rh_q;
  logic [TW-1:0]          tmo_q;
  logic                   kerr_q;
  logic [COUNT_WIDTH-1:0] cnt_q;

  // A restart in the same cycle blocks acceptance so no byte is lost silently.
  assign bus.data_in_ready           = (state_q == IDLE) && !session_start;
  assign bus.data_out                = dout_q;
  assign bus.data_out_valid          = dval_q;
  assign bus.request_hash_byte_pulse = req_q;
  assign reset_hash                  = rh_q;
  assign byte_count                  = cnt_q;
  assign key_error                   = kerr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      req_q   <= 1'b0;
      rh_q    <= 1'b1;   // generator restarts alongside us
      tmo_q   <= '0;
      kerr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      req_q <= 1'b0;
      rh_q  <= 1'b0;
      if (session_start) begin
        state_q <= IDLE;
        dval_q  <= 1'b0;
        rh_q    <= 1'b1;
        tmo_q   <= '0;
        kerr_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: if (bus.data_in_valid) begin
            hold_q  <= bus.data_in;
            req_q   <= 1'b1;     // pulse is visible during the REQUEST cycle
            state_q <= REQUEST;
          end
          REQUEST: begin
            tmo_q   <= '0;
            state_q <= WAIT_KEY;
          end
          WAIT_KEY: begin
            tmo_q <= tmo_q + 1'b1;
            // Strobe is tested first so it wins on the last timeout cycle.
            if (bus.hash_byte_pulse_in) begin
              dout_q  <= hold_q ^ bus.hash_byte_in;
              dval_q  <= 1'b1;
              state_q <= OUTPUT;
            end else if (tmo_q == TMO_LAST) begin
              kerr_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          OUTPUT: if (bus.data_out_ready) begin
            dval_q  <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keystream_xor.sv
// Scoreboard bench for keystream_xor: a generator model answers requests
// from a key queue; expected outputs (data ^ key) are queued at issue time
// and a monitor pops and compares on every output handshake.
module tb_keystream_xor;
  localparam int KT = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          session_start = 1'b0;
  logic          reset_hash;
  logic [CW-1:0] byte_count;
  logic          key_error;

  keystream_xor_if bus ();

  keystream_xor #(.KEY_TIMEOUT(KT), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .session_start(session_start), .bus(bus),
    .reset_hash(reset_hash), .byte_count(byte_count), .key_error(key_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];     // expected outputs
  logic [7:0] key_q[$];  // keystream the generator will hand out

  int gen_on = 1;
  int gen_delay = 2;
  int stray_req = 0;
  int stray_done = 0;
  int req_count = 0;
  int rh_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Generator model: strobe gen_delay cycles after the request cycle.
  initial begin
    int pend = 0;
    bus.hash_byte_in       = 8'h00;
    bus.hash_byte_pulse_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.request_hash_byte_pulse === 1'b1 && gen_on != 0) pend = gen_delay;
      @(posedge clk);
      #1;
      bus.hash_byte_pulse_in = 1'b0;
      if (stray_req != stray_done) begin
        stray_done++;
        bus.hash_byte_pulse_in = 1'b1;
        bus.hash_byte_in = 8'($urandom);
      end else if (pend > 0) begin
        pend--;
        if (pend == 0 && key_q.size() > 0) begin
          bus.hash_byte_pulse_in = 1'b1;
          bus.hash_byte_in = key_q.pop_front();
        end
      end
    end
  end

  // Output monitor: a handshake completes on the next edge unless a restart overrides it.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !session_start && bus.data_out_valid === 1'b1 && bus.data_out_ready === 1'b1) begin
        if (sb.size() == 0) check("unexpected_output", {24'd0, bus.data_out}, 32'hFFFF_FFFF);
        else check("data_out", {24'd0, bus.data_out}, {24'd0, sb.pop_front()});
      end
    end
  end

  // Pulse properties and counters.
  initial begin
    logic prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("req_and_reset_hash", {31'd0, bus.request_hash_byte_pulse & reset_hash}, 32'd0);
        check("req_back_to_back", {31'd0, bus.request_hash_byte_pulse & prev_req}, 32'd0);
        if (bus.request_hash_byte_pulse) req_count++;
        if (reset_hash) rh_count++;
        prev_req = bus.request_hash_byte_pulse;
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1;
    bus.data_in = d;
    bus.data_in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.data_in_ready) break;
      n++;
      if (n > 200) break;
      @(posedge clk); #1;
    end
    check("send_accepted", {31'd0, n <= 200}, 32'd1);
    @(posedge clk); #1;
    bus.data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.data_out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", {31'd0, n < 300}, 32'd1);
  endtask

  initial begin
    int r0, h0;
    logic [7:0] d;
    bus.data_in = 8'h00;
    bus.data_in_valid = 1'b0;
    bus.data_out_ready = 1'b1;

    // Reset: two edges
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_reset_hash", {31'd0, reset_hash}, 32'd1);
    check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    check("rst_data_out_valid", {31'd0, bus.data_out_valid}, 32'd0);
    check("rst_request", {31'd0, bus.request_hash_byte_pulse}, 32'd0);
    check("rst_byte_count", {28'd0, byte_count}, 32'd0);
    check("rst_key_error", {31'd0, key_error}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_reset_hash", {31'd0, reset_hash}, 32'd1);
    check("rst_data_in_ready", {31'd0, bus.data_in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_reset_hash", {31'd0, reset_hash}, 32'd0);
    check("post_rst_data_in_ready", {31'd0, bus.data_in_ready}, 32'd1);

    // Single byte
    r0 = req_count;
    key_q.push_back(8'hC3);
    sb.push_back(8'h99);
    send(8'h5A);
    drain();
    @(negedge clk);
    check("single_byte_count", {28'd0, byte_count}, 32'd1);
    check("single_req_count", req_count - r0, 32'd1);
    check("single_valid_dropped", {31'd0, bus.data_out_valid}, 32'd0);

    // Backpressure
    bus.data_out_ready = 1'b0;
    r0 = req_count;
    key_q.push_back(8'hC3);
    sb.push_back(8'h99);
    send(8'h5A);
    begin
      int n = 0;
      while (!bus.data_out_valid && n < 50) begin @(negedge clk); n++; end
      check("bp_valid_seen", {31'd0, n < 50}, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data_out", {24'd0, bus.data_out}, 32'h99);
      check("bp_valid", {31'd0, bus.data_out_valid}, 32'd1);
      check("bp_data_in_ready", {31'd0, bus.data_in_ready}, 32'd0);
    end
    check("bp_req_count", req_count - r0, 32'd1);
    @(posedge clk); #1;
    bus.data_out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("bp_byte_count", {28'd0, byte_count}, 32'd2);

    // Timeout: error rises KT cycles after the first WAIT_KEY cycle
    gen_on = 0;
    send(8'h11);
    repeat (KT) @(posedge clk);
    @(negedge clk);
    check("tmo_key_error_early", {31'd0, key_error}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("tmo_key_error", {31'd0, key_error}, 32'd1);
    check("tmo_byte_count", {28'd0, byte_count}, 32'd2);
    check("tmo_idle", {31'd0, bus.data_in_ready}, 32'd1);
    check("tmo_no_output", {31'd0, bus.data_out_valid}, 32'd0);

    // Later success keeps the sticky error
    gen_on = 1;
    d = 8'($urandom);
    key_q.push_back(8'h3C);
    sb.push_back(d ^ 8'h3C);
    send(d);
    drain();
    @(negedge clk);
    check("sticky_key_error", {31'd0, key_error}, 32'd1);
    check("sticky_byte_count", {28'd0, byte_count}, 32'd3);

    // Session restart in WAIT_KEY, stray strobe one cycle later
    gen_on = 0;
    send(8'h77);
    @(posedge clk); #1;
    h0 = rh_count;
    session_start = 1'b1;
    @(negedge clk);
    stray_req++;
    @(posedge clk); #1;
    session_start = 1'b0;
    @(negedge clk);
    check("ss_reset_hash", {31'd0, reset_hash}, 32'd1);
    check("ss_byte_count", {28'd0, byte_count}, 32'd0);
    check("ss_key_error", {31'd0, key_error}, 32'd0);
    check("ss_stray_strobe_seen", {31'd0, bus.hash_byte_pulse_in}, 32'd1);
    repeat (4) @(negedge clk);
    check("ss_reset_hash_once", rh_count - h0, 32'd1);
    check("ss_no_output", {31'd0, bus.data_out_valid}, 32'd0);
    check("ss_byte_count_after", {28'd0, byte_count}, 32'd0);
    check("ss_idle", {31'd0, bus.data_in_ready}, 32'd1);

    // Strobe on the last timeout cycle wins over the timeout
    gen_on = 1;
    gen_delay = KT;
    d = 8'($urandom);
    key_q.push_back(8'hA5);
    sb.push_back(d ^ 8'hA5);
    send(d);
    drain();
    @(negedge clk);
    check("edge_key_error", {31'd0, key_error}, 32'd0);
    check("edge_byte_count", {28'd0, byte_count}, 32'd1);

    // Stream of 17 bytes with keys 0x00..0x10; count wraps
    for (int i = 0; i <= 16; i++) begin
      gen_delay = $urandom_range(1, 4);
      d = 8'($urandom);
      key_q.push_back(8'(i));
      sb.push_back(d ^ 8'(i));
      send(d);
    end
    drain();
    @(negedge clk);
    check("wrap_byte_count", {28'd0, byte_count}, 32'd2);
    check("wrap_key_error", {31'd0, key_error}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
